// File: rtl/piano_pkg.sv
// Shared constants for the one-octave piano: key count, note pitches,
// divider arithmetic and the tone FSM state encoding.
package piano_pkg;

  localparam int NUM_KEYS = 12;

  // C6..B6 in Hz, indexed by semitone above C6
  localparam int NOTE_F [NUM_KEYS] = '{1047, 1109, 1175, 1245, 1319, 1397,
                                       1480, 1568, 1661, 1760, 1865, 1976};

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  function automatic int half_period(input int clk_hz, input int f);
    return (clk_hz / 2) / f;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser followed by a two-sample agreement filter
// that only advances on the shared sample tick.
module key_debounce (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key,
  output logic db
);

  logic sync1, sync2, sample;

  // db follows the key only once two consecutive tick samples agree
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sample <= 1'b0;
      db     <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if (tick) begin
        sample <= sync2;
        if (sync2 == sample) db <= sync2;
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Debounces the octave's keys, picks the last-pressed one and drives a
// single shared half-period divider producing the square-wave tone.
module note_scheduler
  import piano_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                ClkRedu,
  output logic                note_active,
  output logic [3:0]          note_idx
);

  localparam int TICK_W = $clog2(DEBOUNCE_CYCLES);

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] db, db_q, rise;
  logic                sel_valid, sel_valid_nxt;
  logic [3:0]          sel_idx, sel_idx_nxt;
  logic [14:0]         half_tab [NUM_KEYS];
  logic [14:0]         period, cnt;
  state_t              state;

  assign tick = (tick_cnt == TICK_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_key
    key_debounce u_debounce (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .key   (keys[g]),
      .db    (db[g])
    );
    assign half_tab[g] = 15'(half_period(CLK_HZ, NOTE_F[g]));
  end

  assign rise = db & ~db_q;

  // A fresh press always wins; losing the selected key falls back to the
  // lowest key still held, and other releases are ignored.
  always_comb begin
    sel_valid_nxt = sel_valid;
    sel_idx_nxt   = sel_idx;
    if (|rise) begin
      sel_valid_nxt = 1'b1;
      sel_idx_nxt   = lowest_set(rise);
    end else if (sel_valid && !db[sel_idx]) begin
      sel_valid_nxt = |db;
      if (|db) sel_idx_nxt = lowest_set(db);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      db_q      <= '0;
      sel_valid <= 1'b0;
      sel_idx   <= '0;
    end else begin
      db_q      <= db;
      sel_valid <= sel_valid_nxt;
      sel_idx   <= sel_idx_nxt;
    end
  end

  // A selection change outranks a terminal count, so the tone restarts low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= '0;
      ClkRedu     <= 1'b0;
      note_active <= 1'b0;
      note_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt         <= '0;
          ClkRedu     <= 1'b0;
          note_active <= 1'b0;
          if (sel_valid) state <= LOAD;
        end
        LOAD: begin
          period      <= half_tab[sel_idx];
          cnt         <= '0;
          ClkRedu     <= 1'b0;
          note_idx    <= sel_idx;
          note_active <= 1'b1;
          state       <= PLAY;
        end
        PLAY: begin
          if (!sel_valid) begin
            state       <= IDLE;
            cnt         <= '0;
            ClkRedu     <= 1'b0;
            note_active <= 1'b0;
          end else if (sel_idx != note_idx) begin
            state   <= LOAD;
            cnt     <= '0;
            ClkRedu <= 1'b0;
          end else if (cnt == period - 15'd1) begin
            cnt     <= '0;
            ClkRedu <= ~ClkRedu;
          end else begin
            cnt <= cnt + 15'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: key-pattern table, randomized patterns against an
// event-level selection model, and timed sequences for the tone divider.
module tb_note_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] keys = '0;
  logic        ClkRedu;
  logic        note_active;
  logic [3:0]  note_idx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] pattern;
    int          hold;
    logic        active;
    logic [3:0]  idx;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  note_scheduler #(
    .CLK_HZ          (50_000_000),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keys        (keys),
    .ClkRedu     (ClkRedu),
    .note_active (note_active),
    .note_idx    (note_idx)
  );

  initial begin
    #(2_000_000);
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] pat, input int cycles);
    keys = pat;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkState(input string name, input logic active, input logic [3:0] idx);
    checkOutput({name, " active"}, int'(note_active), int'(active));
    if (active) checkOutput({name, " idx"}, int'(note_idx), int'(idx));
    checkOutput({name, " tone"}, int'(ClkRedu), 0);
  endtask

  task automatic waitActive(input string name, input logic want, input int bound);
    int n = 0;
    while (note_active !== want && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " reached"}, int'(note_active), int'(want));
  endtask

  task automatic waitIdx(input string name, input logic [3:0] idx, input int bound);
    int n = 0;
    while (!(note_active === 1'b1 && note_idx === idx) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " idx"}, int'(note_idx), int'(idx));
  endtask

  // Counts cycles until ClkRedu leaves the given level.
  task automatic measurePhase(input string name, input logic level, input int expected);
    int n = 0;
    while (ClkRedu === level && n < 30000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, n, expected);
  endtask

  function automatic logic [3:0] lowestKey(input logic [11:0] v);
    for (int i = 0; i < 12; i++) begin
      if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  initial begin
    logic [11:0] prevPat, newPat, risen;
    logic        mValid;
    logic [3:0]  mIdx;
    logic        seen;

    vecs[0]  = '{12'h000, 24, 1'b0, 4'd0};
    vecs[1]  = '{12'h010, 24, 1'b1, 4'd4};
    vecs[2]  = '{12'h090, 24, 1'b1, 4'd7};
    vecs[3]  = '{12'h010, 24, 1'b1, 4'd4};
    vecs[4]  = '{12'h000, 24, 1'b0, 4'd0};
    vecs[5]  = '{12'h090, 24, 1'b1, 4'd4};
    vecs[6]  = '{12'h080, 24, 1'b1, 4'd7};
    vecs[7]  = '{12'h884, 24, 1'b1, 4'd2};
    vecs[8]  = '{12'h880, 24, 1'b1, 4'd7};
    vecs[9]  = '{12'h800, 24, 1'b1, 4'd11};
    vecs[10] = '{12'h801, 24, 1'b1, 4'd0};
    vecs[11] = '{12'h001, 24, 1'b1, 4'd0};
    vecs[12] = '{12'h000, 24, 1'b0, 4'd0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset tone", int'(ClkRedu), 0);
    checkOutput("reset active", int'(note_active), 0);
    checkOutput("reset idx", int'(note_idx), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].pattern, vecs[i].hold);
      checkState($sformatf("vec%0d", i), vecs[i].active, vecs[i].idx);
    end

    prevPat = '0;
    mValid  = 1'b0;
    mIdx    = '0;
    for (int s = 0; s < 40; s++) begin
      newPat = prevPat ^ (12'h001 << $urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) newPat = newPat ^ (12'h001 << $urandom_range(0, 11));
      if ($urandom_range(0, 9) == 0) newPat = '0;
      risen = newPat & ~prevPat;
      if (risen != 0) begin
        mValid = 1'b1;
        mIdx   = lowestKey(risen);
      end else if (mValid && !newPat[mIdx]) begin
        mValid = (newPat != 0);
        if (mValid) mIdx = lowestKey(newPat);
      end
      applyStimulus(newPat, $urandom_range(20, 40));
      checkState($sformatf("rand%0d", s), mValid, mIdx);
      prevPat = newPat;
    end
    applyStimulus(12'h000, 30);

    keys = 12'h002;
    waitActive("key1 start", 1'b1, 40);
    checkOutput("key1 idx", int'(note_idx), 1);
    checkOutput("key1 start tone", int'(ClkRedu), 0);
    measurePhase("key1 first rise", 1'b0, 22542);
    measurePhase("key1 high phase", 1'b1, 22542);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midreset tone", int'(ClkRedu), 0);
    checkOutput("midreset active", int'(note_active), 0);
    checkOutput("midreset idx", int'(note_idx), 0);
    waitActive("key1 after reset", 1'b1, 40);
    checkOutput("key1 after reset idx", int'(note_idx), 1);
    applyStimulus(12'h000, 30);
    checkOutput("key1 released", int'(note_active), 0);

    seen = 1'b0;
    for (int i = 0; i < 42; i++) begin
      keys = (i % 3 == 0) ? 12'h001 : 12'h000;
      @(negedge clk);
      if (note_active) seen = 1'b1;
    end
    keys = '0;
    repeat (20) begin
      @(negedge clk);
      if (note_active) seen = 1'b1;
    end
    checkOutput("bounce rejected", int'(seen), 0);

    keys = 12'h001;
    waitActive("key0 start", 1'b1, 40);
    checkOutput("key0 idx", int'(note_idx), 0);
    keys = 12'h201;
    waitIdx("key9 preempt", 4'd9, 40);
    checkOutput("key9 restart tone", int'(ClkRedu), 0);
    measurePhase("key9 first rise", 1'b0, 14204);
    keys = 12'h001;
    waitIdx("key9 release", 4'd0, 40);
    checkOutput("key0 resume active", int'(note_active), 1);
    checkOutput("key0 resume tone", int'(ClkRedu), 0);
    measurePhase("key0 first rise", 1'b0, 23877);

    keys = 12'h000;
    waitActive("key0 release", 1'b0, 40);
    keys = 12'h800;
    waitIdx("key11 start", 4'd11, 40);
    repeat (30) @(negedge clk);
    keys = 12'h000;
    waitActive("key11 release", 1'b0, 40);
    checkOutput("key11 silent tone", int'(ClkRedu), 0);
    checkOutput("key11 idx kept", int'(note_idx), 11);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (ClkRedu || note_active) seen = 1'b1;
    end
    checkOutput("silence holds", int'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Shares a single programmable tone divider among the twelve piano keys of one octave (C6–B6). It synchronises and debounces the raw key inputs and picks one key to sound, using last-pressed priority. It then loads that key's half-period count and produces a 50 %-duty square wave on `ClkRedu`. It replaces the per-note fixed dividers and sits between the key buttons and the speaker pin.

## Interface
- `NUM_KEYS`, 12: number of key inputs; the index is the semitone above C6.
- `CLK_HZ`, 50_000_000: system clock frequency.
- `DEBOUNCE_CYCLES`, 500_000: sample-tick period (10 ms at the default clock); minimum 2.

- `clk`  in  1  system clock; all logic acts on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `keys`  in  NUM_KEYS  raw, asynchronous, active-high key buttons.
- `ClkRedu`  out  1  square-wave tone to the speaker.
- `note_active`  out  1  high while a note is sounding.
- `note_idx`  out  4  index of the selected key; meaningful only while `note_active` is high.

## Operation
- **Synchroniser:** two flip-flops per key, reset to 0.
- **Sample tick:** a free-running counter pulses once every `DEBOUNCE_CYCLES` clocks.
  - On each tick, a key's debounced state `db[i]` takes the synchronised value only if the previous tick's sample was the same.
  - A key change is therefore accepted after two stable samples.
- **Key selection:**
  - A rising edge of `db[i]` selects key `i`.
  - If several keys rise on the same tick, the lowest index wins.
  - If the selected key's `db` falls while other keys are held, the lowest-index held key is selected.
  - If no key is held, there is no selection.
  - A falling edge of any non-selected key leaves the selection unchanged.
- **Half-period table:** `HALF[i] = (CLK_HZ/2) / f[i]` using integer division.
  - `f` = 1047, 1109, 1175, 1245, 1319, 1397, 1480, 1568, 1661, 1760, 1865, 1976 Hz.
  - Defaults: `HALF[0]` = 23877, `HALF[1]` = 22542, `HALF[9]` = 14204, `HALF[11]` = 12651.
  - Divider counter width: 15 bits.
- **FSM states:**
  - IDLE: `ClkRedu` = 0, counter held at 0. Goes to LOAD when a selection exists.
  - LOAD: lasts one cycle. Latches `HALF[sel]` into the period register, clears the counter, forces `ClkRedu` to 0, sets `note_idx` = sel and `note_active` = 1. Always goes to PLAY.
  - PLAY: the counter increments every cycle. When counter = period − 1, the counter returns to 0 and `ClkRedu` toggles.
    - If the selection changes to a different key, go to LOAD; the note restarts with `ClkRedu` low (phase is not preserved).
    - If the selection disappears, go to IDLE: `ClkRedu` = 0 and `note_active` = 0 on the next cycle; `note_idx` keeps its last value.
- **Priority of events:** a selection change and a counter terminal count in the same cycle resolve as the selection change; that cycle's toggle is dropped.
- **Reset** (`reset` = 0 on a clock edge, including mid-note) clears:
  - synchroniser, sample and `db` registers, tick counter, divider counter, period register, selection;
  - FSM returns to IDLE;
  - `ClkRedu` = 0, `note_active` = 0, `note_idx` = 0.

## Timing
- Cycle T is the cycle whose registered `db` shows the change.
  - T+1: selection register updates.
  - T+2: FSM is in LOAD.
  - T+3: FSM is in PLAY with the counter at 0.
- First `ClkRedu` rise: at cycle T+3+`HALF[sel]`. Every later half-period lasts exactly `HALF[sel]` clocks, so the tone period is 2·HALF.
- Key-to-debounced latency: one to two tick periods plus 2 synchroniser cycles.
- Release to silence: `db` fall at T gives `ClkRedu` = 0 and `note_active` = 0 at T+2.
- No handshake; the outputs are registered and drive pins directly.

## Structure
- Shared package `piano_pkg`:
  - `NUM_KEYS`;
  - the note-frequency constant array `f`;
  - a `half_period(clk_hz, f)` constant function;
  - FSM state typedef {IDLE, LOAD, PLAY}.
- Sub-module `key_debounce`: holds the synchroniser and the two-sample agreement for a single key, is driven by the shared tick, and is instantiated `NUM_KEYS` times. The tick generator, selection logic and FSM stay in `note_scheduler`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and the default `CLK_HZ`.
- **Reset mid-note:** hold key 1 until PLAY, then pulse `reset` = 0 for one edge → next cycle `ClkRedu` = 0, `note_active` = 0, `note_idx` = 0, IDLE; while key 1 is still held, the note re-enters LOAD after re-debounce.
- **Single key:** press key 1 and hold → `note_idx` = 1; `ClkRedu` rises exactly 22542 cycles after PLAY entry; high and low phases each 22542 cycles.
- **Bounce rejection:** toggle key 0 every 3 cycles for 40 cycles, then release → `db[0]` never asserts, `note_active` stays 0.
- **Last-pressed priority:** hold key 0 until it sounds, then press key 9 → `note_idx` = 9, half-period 14204. Release key 9 → `note_idx` = 0, half-period 23877, with LOAD seen and `ClkRedu` low at the restart.
- **Simultaneous press:** keys 4 and 7 rise on the same tick → `note_idx` = 4.
- **Release all:** from PLAY on key 11, release → `ClkRedu` = 0 and `note_active` = 0 two cycles after `db[11]` falls, with no further toggles.
